imm_extend_unit: RTL and testbench

- Parametrised, pipelined immediate-generation stage in decode, following the fixed-width combinational sign extender.
- Pulls a short, long or byte immediate field from an instruction word and zero- or sign-extends it to DATA_W.
- Supports an optional prefix instruction that supplies the upper immediate bits to the next instruction.
- Registered output with valid/ready handshake, stall and flush.

---
 rtl/imm_extend_unit_if.sv | 27 ++
 rtl/imm_extend_unit.sv | 117 +++++++++++
 tb/tb_imm_extend_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_unit_if.sv
// Decode-side bus for the immediate extend stage: instruction in, extended immediate out.
// Both directions use valid/ready, and flush travels with the bus.
interface imm_extend_unit_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr;
  logic [1:0]        mode;
  logic              is_prefix;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm;
  logic              prefixed;
  logic              dbl_prefix;

  modport slave (
    input  in_valid, instr, mode, is_prefix, flush, out_ready,
    output in_ready, out_valid, imm, prefixed, dbl_prefix
  );

  modport master (
    output in_valid, instr, mode, is_prefix, flush, out_ready,
    input  in_ready, out_valid, imm, prefixed, dbl_prefix
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Immediate extend stage with prefix support; 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; the output is held until it is taken.
module imm_extend_unit #(
  parameter int DATA_W   = 16,
  parameter int LONG_W   = 9,
  parameter int SHORT_W  = 4,
  parameter int PREFIX_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imm_extend_unit_if.slave      bus
);

  localparam int EXT_W = DATA_W + PREFIX_W;

  if (!(SHORT_W < LONG_W && LONG_W < DATA_W && DATA_W > 8 && PREFIX_W <= DATA_W && SHORT_W > 0))
  begin : g_bad_params
    $error("imm_extend_unit: illegal parameter combination");
  end

  typedef enum logic {IDLE, PEND} state_e;

  state_e              state_q, state_d;
  logic [PREFIX_W-1:0] pref_q, pref_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                prefixed_q, prefixed_d;
  logic                dbl_q, dbl_d;

  logic                accept;
  logic [DATA_W-1:0]   field_z;
  logic [DATA_W-1:0]   plain_imm;
  logic [EXT_W-1:0]    pref_wide;

  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.imm        = imm_q;
  assign bus.prefixed   = prefixed_q;
  assign bus.dbl_prefix = dbl_q;

  // Field extraction; the prefixed form always treats the field as unsigned.
  always_comb begin
    field_z   = '0;
    plain_imm = '0;
    pref_wide = '0;
    case (bus.mode)
      2'b00: begin
        field_z   = DATA_W'(bus.instr[SHORT_W-1:0]);
        plain_imm = field_z;
        pref_wide = (EXT_W'(pref_q) << SHORT_W) | EXT_W'(field_z);
      end
      2'b01: begin
        field_z   = DATA_W'(bus.instr[SHORT_W-1:0]);
        plain_imm = {{(DATA_W-SHORT_W){bus.instr[SHORT_W-1]}}, bus.instr[SHORT_W-1:0]};
        pref_wide = (EXT_W'(pref_q) << SHORT_W) | EXT_W'(field_z);
      end
      2'b10: begin
        field_z   = DATA_W'(bus.instr[LONG_W-1:0]);
        plain_imm = {{(DATA_W-LONG_W){bus.instr[LONG_W-1]}}, bus.instr[LONG_W-1:0]};
        pref_wide = (EXT_W'(pref_q) << LONG_W) | EXT_W'(field_z);
      end
      default: begin
        field_z   = DATA_W'(bus.instr[7:0]);
        plain_imm = field_z;
        pref_wide = (EXT_W'(pref_q) << 8) | EXT_W'(field_z);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pref_d      = pref_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    imm_d       = imm_q;
    prefixed_d  = prefixed_q;
    dbl_d       = 1'b0;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      pref_d      = '0;
    end else if (accept) begin
      if (bus.is_prefix) begin
        pref_d  = bus.instr[PREFIX_W-1:0];
        state_d = PEND;
        dbl_d   = (state_q == PEND);
      end else begin
        out_valid_d = 1'b1;
        imm_d       = (state_q == PEND) ? pref_wide[DATA_W-1:0] : plain_imm;
        prefixed_d  = (state_q == PEND);
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pref_q      <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      prefixed_q  <= 1'b0;
      dbl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pref_q      <= pref_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      prefixed_q  <= prefixed_d;
      dbl_q       <= dbl_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.instr, pref_wide};

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: directed scenarios plus randomized traffic against a reference model.
module tb_imm_extend_unit;
  localparam int DW = 16, LW = 9, SW = 4, PW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_extend_unit_if #(.DATA_W(DW)) bus ();
  imm_extend_unit #(.DATA_W(DW), .LONG_W(LW), .SHORT_W(SW), .PREFIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive(input logic v, input logic p, input logic [1:0] m,
                       input logic [15:0] ins, input logic ordy, input logic fl);
    bus.in_valid = v; bus.is_prefix = p; bus.mode = m;
    bus.instr = ins; bus.out_ready = ordy; bus.flush = fl;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Returns {prefixed, imm} from the arithmetic meaning of each mode.
  function automatic logic [16:0] ref_imm(input bit pend, input longint pref, input int m, input longint ins);
    int f;
    longint field, val;
    f = (m == 2) ? LW : (m == 3) ? 8 : SW;
    field = ins % (longint'(1) << f);
    if (pend) begin
      val = ((pref << f) + field) % 65536;
      return {1'b1, 16'(val)};
    end
    val = field;
    if ((m == 1 || m == 2) && field >= (longint'(1) << (f - 1)))
      val = field + 65536 - (longint'(1) << f);
    return {1'b0, 16'(val)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 16'h0, 1, 0);
    #3;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imm !== 16'h0) begin n_err++; $display("FAIL reset_imm: got %h want 0000", bus.imm); end
    n_cmp++; if (bus.prefixed !== 1'b0) begin n_err++; $display("FAIL reset_prefixed: got %b want 0", bus.prefixed); end
    n_cmp++; if (bus.dbl_prefix !== 1'b0) begin n_err++; $display("FAIL reset_dbl: got %b want 0", bus.dbl_prefix); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_plain();
    logic [1:0]  modes [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [15:0] ins   [4] = '{16'h000F, 16'h000F, 16'h0100, 16'h12A5};
    logic [15:0] exps  [4] = '{16'hFFFF, 16'h000F, 16'hFF00, 16'h00A5};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, modes[i], ins[i], 1, 0);
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL plain_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.imm !== exps[i]) begin n_err++; $display("FAIL plain_imm[%0d]: got %h want %h", i, bus.imm, exps[i]); end
      n_cmp++; if (bus.prefixed !== 1'b0) begin n_err++; $display("FAIL plain_prefixed[%0d]: got %b want 0", i, bus.prefixed); end
      drive(0, 0, 0, 16'h0, 1, 0);
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL plain_drop[%0d]: got %b want 0", i, bus.out_valid); end
      n_cmp++; if (bus.imm !== exps[i]) begin n_err++; $display("FAIL plain_hold[%0d]: got %h want %h", i, bus.imm, exps[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'b00, 16'(i + 1), 1, 0);
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'(i + 1)) begin
        n_err++; $display("FAIL b2b[%0d]: got v=%b imm=%h want v=1 imm=%h", i, bus.out_valid, bus.imm, 16'(i + 1));
      end
    end
    drive(0, 0, 0, 16'h0, 1, 0);
    cycle();
  endtask

  task automatic test_prefix();
    logic [1:0]  modes [2] = '{2'b00, 2'b10};
    logic [15:0] ins   [2] = '{16'h0005, 16'h01FF};
    logic [15:0] exps  [2] = '{16'hABC5, 16'h79FF};
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 2'b00, 16'h0ABC, 1, 0);
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL prefix_no_out[%0d]: got %b want 0", i, bus.out_valid); end
      drive(1, 0, modes[i], ins[i], 1, 0);
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== exps[i]) begin
        n_err++; $display("FAIL prefix_imm[%0d]: got v=%b imm=%h want v=1 imm=%h", i, bus.out_valid, bus.imm, exps[i]);
      end
      n_cmp++; if (bus.prefixed !== 1'b1) begin n_err++; $display("FAIL prefix_flag[%0d]: got %b want 1", i, bus.prefixed); end
      drive(0, 0, 0, 16'h0, 1, 0);
      cycle();
    end
  endtask

  task automatic test_dbl_prefix();
    drive(1, 1, 2'b00, 16'h0111, 1, 0);
    cycle();
    n_cmp++; if (bus.dbl_prefix !== 1'b0) begin n_err++; $display("FAIL dbl_first: got %b want 0", bus.dbl_prefix); end
    drive(1, 1, 2'b00, 16'h0222, 1, 0);
    cycle();
    n_cmp++; if (bus.dbl_prefix !== 1'b1) begin n_err++; $display("FAIL dbl_pulse: got %b want 1", bus.dbl_prefix); end
    drive(1, 0, 2'b00, 16'h0003, 1, 0);
    cycle();
    n_cmp++; if (bus.dbl_prefix !== 1'b0) begin n_err++; $display("FAIL dbl_end: got %b want 0", bus.dbl_prefix); end
    n_cmp++; if (bus.imm !== 16'h2223 || bus.prefixed !== 1'b1) begin
      n_err++; $display("FAIL dbl_imm: got imm=%h p=%b want imm=2223 p=1", bus.imm, bus.prefixed);
    end
    drive(0, 0, 0, 16'h0, 1, 0);
    cycle();
  endtask

  task automatic test_backpressure();
    drive(1, 0, 2'b01, 16'h0008, 0, 0);
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'hFFF8) begin
      n_err++; $display("FAIL bp_first: got v=%b imm=%h want v=1 imm=fff8", bus.out_valid, bus.imm);
    end
    drive(1, 0, 2'b00, 16'h0007, 0, 0);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'hFFF8) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b imm=%h want v=1 imm=fff8", i, bus.out_valid, bus.imm);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_up: got %b want 1", bus.in_ready); end
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'h0007) begin
      n_err++; $display("FAIL bp_second: got v=%b imm=%h want v=1 imm=0007", bus.out_valid, bus.imm);
    end
    drive(0, 0, 0, 16'h0, 1, 0);
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive(1, 1, 2'b00, 16'h0ABC, 1, 0);
    cycle();
    drive(1, 0, 2'b00, 16'h0009, 1, 1);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %b want 0", bus.out_valid); end
    drive(1, 0, 2'b00, 16'h0003, 1, 0);
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'h0003 || bus.prefixed !== 1'b0) begin
      n_err++; $display("FAIL flush_after: got v=%b imm=%h p=%b want v=1 imm=0003 p=0", bus.out_valid, bus.imm, bus.prefixed);
    end
    drive(0, 0, 0, 16'h0, 1, 0);
    cycle();
  endtask

  task automatic test_reset_mid_prefix();
    drive(1, 1, 2'b00, 16'h0ABC, 1, 0);
    cycle();
    drive(0, 0, 0, 16'h0, 1, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1, 0, 2'b00, 16'h0003, 1, 0);
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.imm !== 16'h0003 || bus.prefixed !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got v=%b imm=%h p=%b want v=1 imm=0003 p=0", bus.out_valid, bus.imm, bus.prefixed);
    end
    drive(0, 0, 0, 16'h0, 1, 0);
    cycle();
  endtask

  task automatic test_random();
    bit m_ov = 0, m_dbl = 0, m_pfx = 0, m_pend = 0;
    logic [15:0] m_imm = 16'h0;
    longint m_pref = 0;
    logic v, p, ordy, fl, exp_rdy;
    logic [1:0] m;
    logic [15:0] ins;
    logic [16:0] r;
    drive(0, 0, 0, 16'h0, 1, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 3) == 0);
      m = 2'($urandom_range(0, 3));
      ins = 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      drive(v, p, m, ins, ordy, fl);
      #1;
      exp_rdy = !m_ov || ordy;
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_rdy); end
      m_dbl = 0;
      if (fl) begin
        m_ov = 0; m_pend = 0; m_pref = 0;
      end else begin
        if (m_ov && ordy) m_ov = 0;
        if (v && exp_rdy) begin
          if (p) begin
            m_dbl = m_pend; m_pend = 1; m_pref = longint'(ins) % (longint'(1) << PW);
          end else begin
            r = ref_imm(m_pend, m_pref, int'(m), longint'(ins));
            m_pfx = r[16]; m_imm = r[15:0]; m_ov = 1; m_pend = 0;
          end
        end
      end
      cycle();
      n_cmp++; if (bus.out_valid !== m_ov || bus.dbl_prefix !== m_dbl) begin
        n_err++; $display("FAIL rnd_ctrl[%0d]: got v=%b dbl=%b want v=%b dbl=%b", i, bus.out_valid, bus.dbl_prefix, m_ov, m_dbl);
      end
      n_cmp++; if (bus.imm !== m_imm || bus.prefixed !== m_pfx) begin
        n_err++; $display("FAIL rnd_imm[%0d]: got imm=%h p=%b want imm=%h p=%b", i, bus.imm, bus.prefixed, m_imm, m_pfx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_back_to_back();
    test_prefix();
    test_dbl_prefix();
    test_backpressure();
    test_flush();
    test_reset_mid_prefix();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
